urng_scheduler: RTL and testbench

Shared uniform-random-number source for the AWGN generator. The block holds one seedable three-component Tausworthe generator and hands its 32-bit outputs to up to NUM_REQ consumers, such as Box-Muller lanes and test taps, under round-robin arbitration. Every output word goes to exactly one consumer. It also sequences seed loading and a post-seed warm-up, so consumers never see un-mixed state.

---
 rtl/awgn_pkg.sv | 26 ++
 rtl/urng_scheduler_if.sv | 32 +++
 rtl/urng_scheduler_taus_core.sv | 48 ++++
 rtl/urng_scheduler.sv | 140 ++++++++++++++
 tb/tb_urng_scheduler.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/awgn_pkg.sv
// Shared definitions for the AWGN uniform-random-number source.
// Holds the Tausworthe default seeds, the minimum legal seed per component
// (smaller values collapse the component into a short or all-zero cycle),
// the scheduler FSM state encoding and the seed validity check.
package awgn_pkg;

    localparam logic [31:0] SEED0_DEFAULT = 32'h0F0F0F0F;
    localparam logic [31:0] SEED1_DEFAULT = 32'h0C0C0C0C;
    localparam logic [31:0] SEED2_DEFAULT = 32'h00FF00FF;

    localparam logic [31:0] SEED0_MIN = 32'd2;
    localparam logic [31:0] SEED1_MIN = 32'd8;
    localparam logic [31:0] SEED2_MIN = 32'd16;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } sched_state_t;

    function automatic logic seeds_valid(input logic [31:0] s0,
                                         input logic [31:0] s1,
                                         input logic [31:0] s2);
        return (s0 >= SEED0_MIN) && (s1 >= SEED1_MIN) && (s2 >= SEED2_MIN);
    endfunction

endpackage

// File: rtl/urng_scheduler_if.sv
// Consumer-facing bus of the uniform-random-number scheduler.
//   seed_load, seed0..seed2 : seed strobe and new component seeds
//   seed_err                : one-cycle pulse, last seed_load rejected
//   ready                   : scheduler is in RUN and can grant
//   req                     : per-requester request levels
//   gnt                     : registered one-hot grant, one cycle wide
//   rnd_out, rnd_valid      : word delivered with gnt, rnd_valid = |gnt
// master = consumer / seeding side, slave = scheduler.
interface urng_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic               seed_load;
    logic [31:0]        seed0;
    logic [31:0]        seed1;
    logic [31:0]        seed2;
    logic               seed_err;
    logic               ready;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [31:0]        rnd_out;
    logic               rnd_valid;

    modport master (
        output seed_load, seed0, seed1, seed2, req,
        input  seed_err, ready, gnt, rnd_out, rnd_valid
    );

    modport slave (
        input  seed_load, seed0, seed1, seed2, req,
        output seed_err, ready, gnt, rnd_out, rnd_valid
    );
endinterface

// File: rtl/urng_scheduler_taus_core.sv
// Three-component Tausworthe generator (taus_core).
//   clock, reset : clock and async active-high reset (restores default seeds)
//   load         : write seed0..seed2 into the component registers
//   seed0..seed2 : component seeds
//   advance      : take one generator step
//   word         : combined output S0 ^ S1 ^ S2 of the current state
// load takes priority over advance; the scheduler never asserts both.
module taus_core
    import awgn_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] seed0,
    input  logic [31:0] seed1,
    input  logic [31:0] seed2,
    input  logic        advance,
    output logic [31:0] word
);

    logic [31:0] s0, s1, s2;
    logic [31:0] s0_next, s1_next, s2_next;

    always_comb begin
        s0_next = ((s0 & 32'hFFFFFFFE) << 12) ^ (((s0 << 13) ^ s0) >> 19);
        s1_next = ((s1 & 32'hFFFFFFF8) << 4)  ^ (((s1 << 2)  ^ s1) >> 25);
        s2_next = ((s2 & 32'hFFFFFFF0) << 17) ^ (((s2 << 3)  ^ s2) >> 11);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s0 <= SEED0_DEFAULT;
            s1 <= SEED1_DEFAULT;
            s2 <= SEED2_DEFAULT;
        end else if (load) begin
            s0 <= seed0;
            s1 <= seed1;
            s2 <= seed2;
        end else if (advance) begin
            s0 <= s0_next;
            s1 <= s1_next;
            s2 <= s2_next;
        end
    end

    assign word = s0 ^ s1 ^ s2;

endmodule

// File: rtl/urng_scheduler.sv
// Uniform-random-number scheduler: one Tausworthe generator shared by up to
// NUM_REQ consumers under round-robin arbitration, with seed loading and a
// post-seed warm-up so consumers never see un-mixed generator state.
//   clock, reset : clock and async active-high reset
//   bus          : urng_scheduler_if slave (seeding, req/gnt, rnd_out)
// Parameters: NUM_REQ (2..8) requesters, WARMUP (0..255) discarded steps.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_WARMUP | generator advances every cycle, count runs down, req ignored
// ST_RUN    | ready; one grant and one generator step per cycle with req
module urng_scheduler
    import awgn_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WARMUP  = 8
) (
    input  logic              clock,
    input  logic              reset,
    urng_scheduler_if.slave   bus
);

    localparam int           PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0]   WARMUP_CNT  = 8'(WARMUP);
    localparam sched_state_t START_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

    sched_state_t       state, state_n;
    logic [7:0]         cnt, cnt_n;
    logic [PTR_W-1:0]   ptr, ptr_n;
    logic [NUM_REQ-1:0] gnt_q, gnt_n;
    logic               vld_q, vld_n;
    logic [31:0]        rnd_q, rnd_n;
    logic               err_q, err_n;

    logic               core_load;
    logic               core_adv;
    logic [31:0]        core_word;

    logic               arb_found;
    logic [PTR_W-1:0]   arb_win;
    logic [PTR_W:0]     arb_idx;

    taus_core u_core (
        .clock   (clock),
        .reset   (reset),
        .load    (core_load),
        .seed0   (bus.seed0),
        .seed1   (bus.seed1),
        .seed2   (bus.seed2),
        .advance (core_adv),
        .word    (core_word)
    );

    // Cyclic search for the first request at or after the pointer.
    // The index is one bit wider so the wrap works for non-power-of-two NUM_REQ.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (arb_idx >= (PTR_W+1)'(NUM_REQ))
                arb_idx = arb_idx - (PTR_W+1)'(NUM_REQ);
            if (!arb_found && bus.req[arb_idx[PTR_W-1:0]]) begin
                arb_found = 1'b1;
                arb_win   = arb_idx[PTR_W-1:0];
            end
        end
    end

    // seed_load outranks any request in the same cycle, even when rejected.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ptr_n     = ptr;
        core_load = 1'b0;
        core_adv  = 1'b0;
        gnt_n     = '0;
        vld_n     = 1'b0;
        rnd_n     = rnd_q;
        err_n     = 1'b0;

        if (bus.seed_load) begin
            if (seeds_valid(bus.seed0, bus.seed1, bus.seed2)) begin
                core_load = 1'b1;
                ptr_n     = '0;
                cnt_n     = WARMUP_CNT;
                state_n   = START_STATE;
            end else begin
                err_n = 1'b1;
            end
        end else begin
            case (state)
                ST_WARMUP: begin
                    core_adv = 1'b1;
                    cnt_n    = cnt - 8'd1;
                    if (cnt <= 8'd1)
                        state_n = ST_RUN;
                end
                ST_RUN: begin
                    if (arb_found) begin
                        gnt_n[arb_win] = 1'b1;
                        vld_n          = 1'b1;
                        rnd_n          = core_word;
                        core_adv       = 1'b1;
                        ptr_n          = (arb_win == PTR_W'(NUM_REQ-1)) ?
                                         '0 : arb_win + PTR_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= START_STATE;
            cnt   <= WARMUP_CNT;
            ptr   <= '0;
            gnt_q <= '0;
            vld_q <= 1'b0;
            rnd_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
            gnt_q <= gnt_n;
            vld_q <= vld_n;
            rnd_q <= rnd_n;
            err_q <= err_n;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rnd_valid = vld_q;
    assign bus.rnd_out   = rnd_q;
    assign bus.seed_err  = err_q;
    assign bus.ready     = (state == ST_RUN);

endmodule

// File: tb/tb_urng_scheduler.sv
// Scoreboard bench for urng_scheduler. Two instances (WARMUP=0 and WARMUP=8)
// see identical stimulus; each has its own reference model and queue.
module tb_urng_scheduler;

    typedef struct packed {
        int          tag;
        logic [3:0]  g;
        logic [31:0] w;
    } exp_t;

    logic clock;
    logic reset;

    urng_scheduler_if #(.NUM_REQ(4)) bus0 ();
    urng_scheduler_if #(.NUM_REQ(4)) bus8 ();

    urng_scheduler #(.NUM_REQ(4), .WARMUP(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    urng_scheduler #(.NUM_REQ(4), .WARMUP(8)) dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (bus8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    int          wu[2]      = '{0, 8};
    logic [31:0] m_s[2][3];
    int          m_cnt[2];
    int          m_ptr[2];
    bit          exp_ready[2];
    bit          exp_err[2];
    exp_t        q0[$];
    exp_t        q1[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        vectors++;
        if (act !== req_v) begin
            miscompares++;
            $display("FAIL %s: got %h, wanted %h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    // Reference model: generator as three words, warm-up as steps remaining,
    // pointer as an integer requester number.
    task automatic model_reset(input int i);
        m_s[i][0] = 32'h0F0F0F0F;
        m_s[i][1] = 32'h0C0C0C0C;
        m_s[i][2] = 32'h00FF00FF;
        m_cnt[i]  = wu[i];
        m_ptr[i]  = 0;
        exp_ready[i] = (wu[i] == 0);
        exp_err[i]   = 1'b0;
    endtask

    task automatic model_advance(input int i);
        logic [31:0] a, b, c;
        a = m_s[i][0]; b = m_s[i][1]; c = m_s[i][2];
        m_s[i][0] = ((a & 32'hFFFFFFFE) << 12) ^ (((a << 13) ^ a) >> 19);
        m_s[i][1] = ((b & 32'hFFFFFFF8) << 4)  ^ (((b << 2)  ^ b) >> 25);
        m_s[i][2] = ((c & 32'hFFFFFFF0) << 17) ^ (((c << 3)  ^ c) >> 11);
    endtask

    task automatic model_step(input int i, input bit sl, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] c,
                              input logic [3:0] r);
        bit   err;
        int   w;
        int   k;
        exp_t e;
        err = 1'b0;
        w   = -1;
        if (sl) begin
            if (a >= 2 && b >= 8 && c >= 16) begin
                m_s[i][0] = a; m_s[i][1] = b; m_s[i][2] = c;
                m_ptr[i]  = 0;
                m_cnt[i]  = wu[i];
            end else begin
                err = 1'b1;
            end
        end else if (m_cnt[i] > 0) begin
            model_advance(i);
            m_cnt[i]--;
        end else if (r != 4'b0000) begin
            for (int n = 0; n < 4; n++) begin
                k = (m_ptr[i] + n) % 4;
                if (w < 0 && r[k]) w = k;
            end
            e.tag = cyc + 1;
            e.g   = 4'b0001 << w;
            e.w   = m_s[i][0] ^ m_s[i][1] ^ m_s[i][2];
            if (i == 0) q0.push_back(e); else q1.push_back(e);
            model_advance(i);
            m_ptr[i] = (w + 1) % 4;
        end
        exp_ready[i] = (m_cnt[i] == 0);
        exp_err[i]   = err;
    endtask

    task automatic apply(input bit sl, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [3:0] r);
        bus0.seed_load = sl; bus0.seed0 = a; bus0.seed1 = b; bus0.seed2 = c; bus0.req = r;
        bus8.seed_load = sl; bus8.seed0 = a; bus8.seed1 = b; bus8.seed2 = c; bus8.req = r;
        model_step(0, sl, a, b, c, r);
        model_step(1, sl, a, b, c, r);
    endtask

    task automatic drive(input bit sl, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [3:0] r);
        @(negedge clock);
        apply(sl, a, b, c, r);
    endtask

    task automatic mon(input int i, input logic [3:0] g, input logic [31:0] w,
                       input logic v, input logic rdy, input logic err);
        exp_t  e;
        int    qs;
        string nm;
        nm = $sformatf("wu%0d", wu[i]);
        qs = (i == 0) ? q0.size() : q1.size();
        chk({nm, " rnd_valid"}, 64'(v), 64'(|g));
        if (v) begin
            if (qs == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL %s grant: got unexpected gnt %b word %h, wanted none (cycle %0d)",
                         nm, g, w, cyc);
            end else begin
                e = (i == 0) ? q0.pop_front() : q1.pop_front();
                chk({nm, " grant_cycle"}, 64'(cyc), 64'(e.tag));
                chk({nm, " gnt"}, 64'(g), 64'(e.g));
                chk({nm, " rnd_out"}, 64'(w), 64'(e.w));
            end
        end else if (qs > 0) begin
            e = (i == 0) ? q0[0] : q1[0];
            if (e.tag <= cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL %s grant: got none, wanted gnt %b word %h (cycle %0d)",
                         nm, e.g, e.w, cyc);
                if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end
        chk({nm, " ready"}, 64'(rdy), 64'(exp_ready[i]));
        chk({nm, " seed_err"}, 64'(err), 64'(exp_err[i]));
    endtask

    always begin
        @(posedge clock);
        #1;
        cyc++;
        mon(0, bus0.gnt, bus0.rnd_out, bus0.rnd_valid, bus0.ready, bus0.seed_err);
        mon(1, bus8.gnt, bus8.rnd_out, bus8.rnd_valid, bus8.ready, bus8.seed_err);
    end

    task automatic check_reset_values();
        chk("rst gnt0", 64'(bus0.gnt), 64'd0);
        chk("rst gnt8", 64'(bus8.gnt), 64'd0);
        chk("rst rnd_out0", 64'(bus0.rnd_out), 64'd0);
        chk("rst rnd_out8", 64'(bus8.rnd_out), 64'd0);
        chk("rst rnd_valid0", 64'(bus0.rnd_valid), 64'd0);
        chk("rst rnd_valid8", 64'(bus8.rnd_valid), 64'd0);
        chk("rst seed_err0", 64'(bus0.seed_err), 64'd0);
        chk("rst seed_err8", 64'(bus8.seed_err), 64'd0);
        chk("rst ready0", 64'(bus0.ready), 64'd1);
        chk("rst ready8", 64'(bus8.ready), 64'd0);
    endtask

    task automatic idle_inputs();
        bus0.seed_load = 1'b0; bus0.seed0 = '0; bus0.seed1 = '0; bus0.seed2 = '0; bus0.req = '0;
        bus8.seed_load = 1'b0; bus8.seed0 = '0; bus8.seed1 = '0; bus8.seed2 = '0; bus8.req = '0;
    endtask

    task automatic mid_reset();
        repeat (3) drive(1'b0, 0, 0, 0, 4'b1111);
        @(negedge clock);
        apply(1'b0, 0, 0, 0, 4'b1111);
        #2;
        reset = 1'b1;
        idle_inputs();
        q0.delete();
        q1.delete();
        model_reset(0);
        model_reset(1);
        #1;
        chk("midrst gnt0", 64'(bus0.gnt), 64'd0);
        chk("midrst rnd_valid0", 64'(bus0.rnd_valid), 64'd0);
        chk("midrst gnt8", 64'(bus8.gnt), 64'd0);
        chk("midrst rnd_valid8", 64'(bus8.rnd_valid), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        apply(1'b0, 0, 0, 0, 4'b0000);
    endtask

    logic [31:0] ra, rb, rc;
    logic [3:0]  rr;
    bit          rs;

    initial begin
        reset = 1'b1;
        idle_inputs();
        model_reset(0);
        model_reset(1);
        repeat (2) @(posedge clock);
        #1;
        check_reset_values();
        @(negedge clock);
        reset = 1'b0;
        apply(1'b0, 0, 0, 0, 4'b0000);

        // single request, then all four held, then one requester held
        drive(1'b0, 0, 0, 0, 4'b0001);
        repeat (2) drive(1'b0, 0, 0, 0, 4'b0000);
        repeat (5) drive(1'b0, 0, 0, 0, 4'b1111);
        drive(1'b0, 0, 0, 0, 4'b0000);
        repeat (12) drive(1'b0, 0, 0, 0, 4'b0001);

        // rejected seed while requesting, sequence continues
        drive(1'b1, 32'd1, 32'h9ABCDEF0, 32'h0FEDCBA9, 4'b0011);
        repeat (3) drive(1'b0, 0, 0, 0, 4'b0011);

        // boundary seeds: smallest accepted and largest rejected
        drive(1'b1, 32'd2, 32'd7, 32'd16, 4'b1111);
        drive(1'b1, 32'd2, 32'd8, 32'd15, 4'b1111);
        drive(1'b1, 32'd2, 32'd8, 32'd16, 4'b1111);
        repeat (12) drive(1'b0, 0, 0, 0, 4'b1111);

        // valid seed, single requester 2, then pointer restart
        drive(1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h0FEDCBA9, 4'b0000);
        repeat (10) drive(1'b0, 0, 0, 0, 4'b0100);
        drive(1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h0FEDCBA9, 4'b0000);
        repeat (10) drive(1'b0, 0, 0, 0, 4'b1111);

        mid_reset();
        repeat (6) drive(1'b0, 0, 0, 0, 4'b1111);

        for (int n = 0; n < 1500; n++) begin
            rs = ($urandom_range(0, 39) == 0);
            ra = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3))  : 32'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
            rc = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 31)) : 32'($urandom);
            rr = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            drive(rs, ra, rb, rc, rr);
            if (n == 700) mid_reset();
        end

        repeat (4) drive(1'b0, 0, 0, 0, 4'b0000);
        @(negedge clock);
        chk("drain q0", 64'(q0.size()), 64'd0);
        chk("drain q8", 64'(q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
